// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: word width, multiply/divide op codes and
// the sequencer state encoding used by muldiv_seq.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the Booth multiply steps, the
// non-restoring divide steps and the final remainder restore.
module muldiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_y
);

    // Single carry chain: subtract when i_sub is set, otherwise add.
    always_comb begin
        o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide unit feeding ZHI/ZLOW.
// MUL: radix-2 Booth, one bit per clock. DIV: non-restoring on magnitudes,
// one bit per clock, followed by a restore/sign-fix cycle.
// Optional feature: define MULDIV_DIVZERO_EN to add the div_zero output and
// a fast path that finishes a divide by zero without iterating.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] zhi_out,
    output logic [WIDTH-1:0] zlow_out,
    output logic             z_in,
`ifdef MULDIV_DIVZERO_EN
    output logic             div_zero,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t    r_state;
    muldiv_state_t    w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_sa;
    logic             r_sb;
    logic             r_dz;
    logic             r_qm1;
    // r_acc: Booth accumulator for MUL, partial remainder for DIV.
    logic [WIDTH:0]   r_acc;
    // r_m: sign-extended multiplicand for MUL, divisor magnitude for DIV.
    logic [WIDTH:0]   r_m;
    // r_q: multiplier / low product for MUL, dividend then quotient for DIV.
    logic [WIDTH-1:0] r_q;

    logic [WIDTH-1:0] r_zhi;
    logic [WIDTH-1:0] r_zlow;
    logic             r_z_in;
`ifdef MULDIV_DIVZERO_EN
    logic             r_div_zero;
`endif

    logic [WIDTH:0]   w_as_a;
    logic [WIDTH:0]   w_as_b;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_b_zero;
    logic             w_skip;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;

    assign w_b_zero = (b_in == '0);

`ifdef MULDIV_DIVZERO_EN
    assign w_skip = (op == OP_DIV) && w_b_zero;
`else
    assign w_skip = 1'b0;
`endif

    // Operand magnitudes; -2^(WIDTH-1) maps onto itself, read as unsigned.
    always_comb begin
        w_a_mag = a_in[WIDTH-1] ? -a_in : a_in;
        w_b_mag = b_in[WIDTH-1] ? -b_in : b_in;
    end

    // Sign fix-up: quotient negated on differing signs, remainder follows the dividend.
    always_comb begin
        w_rem_fix = r_sa ? -w_sum[WIDTH-1:0] : w_sum[WIDTH-1:0];
        if (r_dz)
            w_quo_fix = '1;
        else
            w_quo_fix = (r_sa ^ r_sb) ? -r_q : r_q;
    end

    // Route the shared adder for the current step.
    always_comb begin
        w_as_a = r_acc;
        w_as_b = '0;
        w_sub  = 1'b0;
        if (r_state == RUN) begin
            if (r_op == OP_MUL) begin
                case ({r_q[0], r_qm1})
                    2'b01:   w_as_b = r_m;
                    2'b10: begin
                        w_as_b = r_m;
                        w_sub  = 1'b1;
                    end
                    default: w_as_b = '0;
                endcase
            end else begin
                w_as_a = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
                w_as_b = r_m;
                w_sub  = ~r_acc[WIDTH];
            end
        end else if (r_state == FIX) begin
            w_as_b = r_acc[WIDTH] ? r_m : '0;
        end
    end

    muldiv_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a   (w_as_a),
        .i_b   (w_as_b),
        .i_sub (w_sub),
        .o_y   (w_sum)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = w_skip ? DONE : RUN;
            RUN:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (r_state == RUN) || (r_state == FIX);
    end

    // Operand latch, iteration datapath and final sign correction.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
            r_op  <= OP_MUL;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_dz  <= 1'b0;
            r_qm1 <= 1'b0;
            r_acc <= '0;
            r_m   <= '0;
            r_q   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_op  <= op;
                        r_sa  <= a_in[WIDTH-1];
                        r_sb  <= b_in[WIDTH-1];
                        r_dz  <= (op == OP_DIV) && w_b_zero;
                        r_qm1 <= 1'b0;
                        if (op == OP_MUL) begin
                            r_acc <= '0;
                            r_q   <= b_in;
                            r_m   <= {a_in[WIDTH-1], a_in};
                        end else begin
                            r_acc <= '0;
                            r_q   <= w_a_mag;
                            r_m   <= {1'b0, w_b_mag};
                            // Fast divide-by-zero path: result is final right away.
                            if (w_skip) begin
                                r_acc <= {a_in[WIDTH-1], a_in};
                                r_q   <= '1;
                            end
                        end
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op == OP_MUL) begin
                        // Arithmetic shift right of {acc, Q, q-1}.
                        r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                        r_qm1 <= r_q[0];
                    end else begin
                        r_acc <= w_sum;
                        r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                    end
                end
                FIX: begin
                    if (r_op == OP_DIV) begin
                        r_acc <= {w_rem_fix[WIDTH-1], w_rem_fix};
                        r_q   <= w_quo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers and the one-cycle Z load strobe, updated in DONE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_zhi  <= '0;
            r_zlow <= '0;
            r_z_in <= 1'b0;
        end else begin
            r_z_in <= (r_state == DONE);
            if (r_state == DONE) begin
                r_zhi  <= r_acc[WIDTH-1:0];
                r_zlow <= r_q;
            end
        end
    end

`ifdef MULDIV_DIVZERO_EN
    // Divide-by-zero flag: raised with z_in, held until the next accepted start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_div_zero <= 1'b0;
        else if ((r_state == IDLE) && start)
            r_div_zero <= 1'b0;
        else if (r_state == DONE)
            r_div_zero <= r_dz;
    end

    assign div_zero = r_div_zero;
`endif

    assign zhi_out  = r_zhi;
    assign zlow_out = r_zlow;
    assign z_in     = r_z_in;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a driver issues operations and pushes the
// arithmetic result expected from plain 64-bit signed math; a monitor pops
// and compares whenever z_in is seen. Honours MULDIV_DIVZERO_EN.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] zhi_out;
    logic [W-1:0] zlow_out;
    logic         z_in;
    logic         busy;
`ifdef MULDIV_DIVZERO_EN
    logic         div_zero;
`endif

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .zhi_out  (zhi_out),
        .zlow_out (zlow_out),
        .z_in     (z_in),
`ifdef MULDIV_DIVZERO_EN
        .div_zero (div_zero),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_z = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic (truncating division).
    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, p, q, r;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        e.dz = 1'b0;
        if (o == 1'b0) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == '0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Monitor: every z_in pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (z_in) begin
            check("z_in single cycle", 64'(prev_z), 64'(0));
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected z_in: zhi=0x%0h zlow=0x%0h, expected no result", zhi_out, zlow_out);
            end else begin
                mon_e = sb.pop_front();
                check("zhi", 64'(zhi_out), 64'(mon_e.hi));
                check("zlow", 64'(zlow_out), 64'(mon_e.lo));
`ifdef MULDIV_DIVZERO_EN
                check("div_zero", 64'(div_zero), 64'(mon_e.dz));
`endif
            end
        end
        prev_z = z_in;
    end

    // Issue one operation; optionally inject ignored starts or a mid-run clear.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ig1, input int ig2, input int clr_at);
        int   m;
        int   lat;
        logic busy_bad;
        logic seen;
        lat = W + 2;
`ifdef MULDIV_DIVZERO_EN
        if (o == 1'b1 && b == '0) lat = 1;
`endif
        @(negedge clk);
        op = o; a_in = a; b_in = b; start = 1'b1;
        if (clr_at < 0) sb.push_back(model(o, a, b));
        busy_bad = 1'b0;
        for (m = 0; m < 60; m++) begin
            @(negedge clk);
            start = (m == ig1) || (m == ig2);
            if (start) begin
                op = ~o; a_in = $urandom; b_in = $urandom;
            end
            if (m == clr_at) begin
                clr = 1'b1;
                #1;
                check("clr busy", 64'(busy), 64'(0));
                check("clr zhi", 64'(zhi_out), 64'(0));
                check("clr zlow", 64'(zlow_out), 64'(0));
                check("clr z_in", 64'(z_in), 64'(0));
                @(negedge clk);
                clr = 1'b0; start = 1'b0;
                seen = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (z_in) seen = 1'b1;
                end
                check("no z_in after clr", 64'(seen), 64'(0));
                return;
            end
            if (z_in) break;
            if (m <= lat - 2 && !busy) busy_bad = 1'b1;
            if (m == lat - 1 && busy) busy_bad = 1'b1;
        end
        start = 1'b0;
        check("latency", 64'(m), 64'(lat));
        check("busy window", 64'(busy_bad), 64'(0));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 200));
            6: return -W'($urandom_range(1, 200));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        clr = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("reset zhi", 64'(zhi_out), 64'(0));
        check("reset zlow", 64'(zlow_out), 64'(0));
        check("reset z_in", 64'(z_in), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        clr = 1'b0;
        @(negedge clk);
        check("post-reset busy", 64'(busy), 64'(0));
        check("post-reset z_in", 64'(z_in), 64'(0));

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1, -1);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1, -1);
        run_op(1'b0, 32'h8000_0000, 32'd1, -1, -1, -1);
        run_op(1'b1, 32'd100, 32'd7, -1, -1, -1);
        run_op(1'b1, -32'd100, 32'd7, -1, -1, -1);
        run_op(1'b1, 32'd100, -32'd7, -1, -1, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        run_op(1'b1, 32'd5, 32'd0, -1, -1, -1);
        run_op(1'b1, -32'd5, 32'd0, -1, -1, -1);
        run_op(1'b0, 32'h1234_5678, -32'd9, 5, 20, -1);
        run_op(1'b1, 32'd1000, 32'd3, -1, -1, 10);
        run_op(1'b0, 32'd3, 32'd4, -1, -1, -1);

        for (int i = 0; i < 40; i++)
            run_op(1'($urandom_range(0, 1)), pick(), pick(), -1, -1, -1);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
